// File: rtl/i2c_target_receiver_if.sv
// I2C target receiver bus bundle.
// Carries the raw I2C pin levels, the target address, the ACK drive and the
// register-file write port (register_address/data/data_valid) plus status.
//   slave  : view of the receiver (pins and address in; ACK, write port, status out)
//   master : view of the environment driving the pins and consuming the writes
interface i2c_target_receiver_if;
  logic       i2c_scl_in;
  logic       i2c_sda_in;
  logic [6:0] own_address;
  logic       i2c_sda_oe;
  logic [7:0] register_address;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       bus_error;

  modport slave (
    input  i2c_scl_in,
    input  i2c_sda_in,
    input  own_address,
    output i2c_sda_oe,
    output register_address,
    output data,
    output data_valid,
    output busy,
    output bus_error
  );

  modport master (
    output i2c_scl_in,
    output i2c_sda_in,
    output own_address,
    input  i2c_sda_oe,
    input  register_address,
    input  data,
    input  data_valid,
    input  busy,
    input  bus_error
  );
endinterface

// File: rtl/i2c_target_receiver.sv
// I2C target receive engine (write transactions only).
// Oversamples SCL/SDA, detects START/STOP, shifts in address, register and
// data bytes, ACKs matching writes and emits one data_valid strobe per data
// byte with its register address. Reads and foreign addresses are NACKed.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : i2c_target_receiver_if.slave (pins, own_address, ACK drive,
//           register write port, busy, bus_error)
// A START/STOP always happens while SCL is high, i.e. after the rising edge
// that already counted one bit. That in-flight bit is not a completed bit, so
// a STOP right after an ACK clock does not flag bus_error.
module i2c_target_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned AUTO_INCREMENT = 1
) (
  input logic                   clock,
  input logic                   reset,
  i2c_target_receiver_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StAddress, StAddrAck, StRegister, StRegAck, StData, StDataAck, StIgnore
  } state_e;

  // Input conditioning
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_h, sda_h;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_h      <= 1'b1;
      sda_h      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], bus.i2c_scl_in};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], bus.i2c_sda_in};
      scl_h      <= scl_s;
      sda_h      <= sda_s;
      scl_rise_q <= scl_s & ~scl_h;
      scl_fall_q <= ~scl_s & scl_h;
      start_q    <= scl_s & ~sda_s & sda_h;
      stop_q     <= scl_s & sda_s & ~sda_h;
    end
  end

  // Protocol FSM
  state_e     state;
  logic [2:0] bit_cnt;
  logic       bit_open;  // a bit was counted on the current SCL high phase
  logic       ack_pend;  // byte complete, ACK goes out on the next SCL fall
  logic [7:0] shreg;
  logic [7:0] pointer;
  logic       sda_oe_q, data_valid_q, busy_q, bus_error_q;
  logic [7:0] reg_addr_q, data_q;
  logic [7:0] byte_full;
  logic       partial_byte;

  // sda_h is the synchronized SDA level from the cycle the rise was detected
  assign byte_full    = {shreg[6:0], sda_h};
  assign partial_byte = (bit_cnt != 3'd0) && !(bit_open && bit_cnt == 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      bit_cnt      <= 3'd0;
      bit_open     <= 1'b0;
      ack_pend     <= 1'b0;
      shreg        <= 8'd0;
      pointer      <= 8'd0;
      sda_oe_q     <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      bus_error_q  <= 1'b0;
      reg_addr_q   <= 8'd0;
      data_q       <= 8'd0;
    end else begin
      data_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      if (scl_fall_q) bit_open <= 1'b0;

      if (start_q || stop_q) begin
        bus_error_q <= partial_byte;
        sda_oe_q    <= 1'b0;
        bit_cnt     <= 3'd0;
        bit_open    <= 1'b0;
        ack_pend    <= 1'b0;
        if (start_q) begin
          state <= StAddress;
        end else begin
          state  <= StIdle;
          busy_q <= 1'b0;
        end
      end else begin
        unique case (state)
          StAddress, StRegister, StData: begin
            if (ack_pend) begin
              if (scl_fall_q) begin
                ack_pend <= 1'b0;
                sda_oe_q <= 1'b1;
                if (state == StAddress) begin
                  busy_q <= 1'b1;
                  state  <= StAddrAck;
                end else if (state == StRegister) begin
                  state <= StRegAck;
                end else begin
                  state <= StDataAck;
                end
              end
            end else if (scl_rise_q) begin
              shreg    <= byte_full;
              bit_open <= 1'b1;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                if (state == StAddress) begin
                  if (byte_full[7:1] == bus.own_address && !byte_full[0]) begin
                    ack_pend <= 1'b1;
                  end else begin
                    busy_q <= 1'b0;
                    state  <= StIgnore;
                  end
                end else if (state == StRegister) begin
                  pointer  <= byte_full;
                  ack_pend <= 1'b1;
                end else begin
                  data_q       <= byte_full;
                  reg_addr_q   <= pointer;
                  data_valid_q <= 1'b1;
                  ack_pend     <= 1'b1;
                  if (AUTO_INCREMENT != 0) pointer <= pointer + 8'd1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          StAddrAck, StRegAck, StDataAck: begin
            if (scl_fall_q) begin
              sda_oe_q <= 1'b0;
              state    <= (state == StAddrAck) ? StRegister : StData;
            end
          end
          StIdle, StIgnore: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign bus.i2c_sda_oe       = sda_oe_q;
  assign bus.register_address = reg_addr_q;
  assign bus.data             = data_q;
  assign bus.data_valid       = data_valid_q;
  assign bus.busy             = busy_q;
  assign bus.bus_error        = bus_error_q;

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Bench for i2c_target_receiver: bit-banged I2C controller with an open-drain
// SDA model, scoreboard queues for data strobes and ACK bits, and monitors
// that pop and compare whenever the DUT presents a strobe or an ACK clock.
module tb_i2c_target_receiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sda_drv = 1'b1;
  logic ack_phase = 1'b0;

  always #5 clock = ~clock;

  i2c_target_receiver_if bus ();

  assign bus.i2c_sda_in  = sda_drv & ~bus.i2c_sda_oe;
  assign bus.own_address = 7'h50;

  i2c_target_receiver #(
    .SYNC_STAGES    (2),
    .AUTO_INCREMENT (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int berr_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] dv_q[$];
  logic        ack_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Data-strobe monitor and strobe counters
  always @(negedge clock) begin
    if (!reset && bus.data_valid) begin
      n_cmp++;
      if (dv_q.size() == 0) begin
        n_err++;
        $display("FAIL dv_unexpected: got addr=%h data=%h, required no strobe",
                 bus.register_address, bus.data);
      end else begin
        logic [15:0] e;
        e = dv_q.pop_front();
        if ({bus.register_address, bus.data} !== e) begin
          n_err++;
          $display("FAIL dv_write: got addr/data=%h, required %h",
                   {bus.register_address, bus.data}, e);
        end
      end
    end
    if (bus.bus_error) berr_cnt++;
    if (bus.i2c_sda_oe) oe_cnt++;
  end

  // ACK monitor: sample the drive at the rising edge of every 9th clock
  always @(posedge bus.i2c_scl_in) begin
    if (ack_phase) begin
      n_cmp++;
      if (ack_q.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: got oe=%b, required no ack clock", bus.i2c_sda_oe);
      end else begin
        logic e;
        e = ack_q.pop_front();
        if (bus.i2c_sda_oe !== e) begin
          n_err++;
          $display("FAIL ack_bit: got oe=%b, required %b", bus.i2c_sda_oe, e);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i];
      wait_clk(6);
      bus.i2c_scl_in = 1'b1;
      wait_clk(12);
      bus.i2c_scl_in = 1'b0;
      wait_clk(6);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    ack_q.push_back(exp_ack);
    send_bits(b, 8);
    sda_drv = 1'b1;
    ack_phase = 1'b1;
    wait_clk(6);
    bus.i2c_scl_in = 1'b1;
    wait_clk(12);
    bus.i2c_scl_in = 1'b0;
    ack_phase = 1'b0;
    wait_clk(6);
  endtask

  // Expects SCL and SDA high on entry
  task automatic start_cond();
    sda_drv = 1'b0;
    wait_clk(12);
    bus.i2c_scl_in = 1'b0;
    wait_clk(6);
  endtask

  // Expects SCL low on entry
  task automatic stop_cond();
    sda_drv = 1'b0;
    wait_clk(6);
    bus.i2c_scl_in = 1'b1;
    wait_clk(12);
    sda_drv = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    bus.i2c_scl_in = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    check("rst_oe", 16'(bus.i2c_sda_oe), 16'h0);
    check("rst_busy", 16'(bus.busy), 16'h0);
    check("rst_dv", 16'(bus.data_valid), 16'h0);
    check("rst_berr", 16'(bus.bus_error), 16'h0);
    check("rst_regaddr", 16'(bus.register_address), 16'h0);
    check("rst_data", 16'(bus.data), 16'h0);

    // Single write 0x34 to register 0x12
    berr_cnt = 0;
    start_cond();
    send_byte(8'hA0, 1'b1);
    check("t1_busy_addr", 16'(bus.busy), 16'h1);
    send_byte(8'h12, 1'b1);
    dv_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    check("t1_busy_data", 16'(bus.busy), 16'h1);
    stop_cond();
    check("t1_busy_stop", 16'(bus.busy), 16'h0);
    check("t1_oe_stop", 16'(bus.i2c_sda_oe), 16'h0);
    check("t1_berr", 16'(berr_cnt), 16'h0);
    check("t1_dv_drained", 16'(dv_q.size()), 16'h0);

    // Auto-increment across the 0xFF -> 0x00 wrap
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'hFE, 1'b1);
    dv_q.push_back(16'hFE01);
    send_byte(8'h01, 1'b1);
    dv_q.push_back(16'hFF02);
    send_byte(8'h02, 1'b1);
    dv_q.push_back(16'h0003);
    send_byte(8'h03, 1'b1);
    stop_cond();
    check("t2_dv_drained", 16'(dv_q.size()), 16'h0);
    check("t2_berr", 16'(berr_cnt), 16'h0);

    // Address mismatch: no ACK, no strobe, not busy
    oe_cnt = 0;
    start_cond();
    send_byte(8'hA2, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    check("t3_busy", 16'(bus.busy), 16'h0);
    stop_cond();
    check("t3_oe_never", 16'(oe_cnt), 16'h0);

    // Read to own address: NACK, then ignored until STOP
    start_cond();
    send_byte(8'hA1, 1'b0);
    check("t4_busy", 16'(bus.busy), 16'h0);
    send_byte(8'h55, 1'b0);
    stop_cond();
    check("t4_oe_never", 16'(oe_cnt), 16'h0);
    check("t4_berr", 16'(berr_cnt), 16'h0);

    // STOP after four bits of the register byte
    berr_cnt = 0;
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_bits(8'h12, 4);
    stop_cond();
    check("t5_berr_once", 16'(berr_cnt), 16'h1);
    check("t5_busy", 16'(bus.busy), 16'h0);
    check("t5_oe", 16'(bus.i2c_sda_oe), 16'h0);

    // Reset while ACKing the address
    start_cond();
    send_bits(8'hA0, 8);
    sda_drv = 1'b1;
    wait_clk(4);
    check("t6_oe_before", 16'(bus.i2c_sda_oe), 16'h1);
    check("t6_busy_before", 16'(bus.busy), 16'h1);
    reset = 1'b1;
    wait_clk(1);
    check("t6_oe_rst", 16'(bus.i2c_sda_oe), 16'h0);
    check("t6_busy_rst", 16'(bus.busy), 16'h0);
    check("t6_regaddr_rst", 16'(bus.register_address), 16'h0);
    check("t6_data_rst", 16'(bus.data), 16'h0);
    reset = 1'b0;
    wait_clk(6);
    bus.i2c_scl_in = 1'b1;
    wait_clk(12);
    start_cond();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h12, 1'b1);
    dv_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    stop_cond();
    check("t6_busy_stop", 16'(bus.busy), 16'h0);

    wait_clk(4);
    check("end_dv_drained", 16'(dv_q.size()), 16'h0);
    check("end_ack_drained", 16'(ack_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_receiver.md
Name: i2c_target_receiver

Overview:
- I2C target (slave) side receive engine. It is the counterpart of the controller-side data engine that shifts address, register and data bytes onto SDA.
- Oversamples SCL/SDA with the system clock, detects START/STOP and shifts in the address byte, register byte and data bytes.
- ACKs matching write transactions by pulling SDA low, then presents each received data byte with its register address to the register file.
- Read transactions are not served: the address byte is NACKed.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on i2c_scl_in and i2c_sda_in (minimum 2).
- AUTO_INCREMENT, 1, when 1 the register address increments (mod 256) after every data byte in a transaction.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- i2c_scl_in  input  1  raw SCL pin level.
- i2c_sda_in  input  1  raw SDA pin level.
- own_address  input  7  target address compared against the first byte after START.
- i2c_sda_oe  output  1  1 = drive SDA low (ACK); 0 = release.
- register_address  output  8  register address of the current data byte.
- data  output  8  received data byte.
- data_valid  output  1  single-cycle strobe; register_address/data valid.
- busy  output  1  high from an addressed START until STOP.
- bus_error  output  1  single-cycle strobe on START/STOP inside a byte (bit counter 1..7).

Behaviour:
- Reset (reset=1 at a clock edge): all outputs 0, FSM to IDLE, bit counter 0, shift register 0, synchronizers set to 1 (idle bus).
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops, plus one history flop each.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-cycle strobes derived from the synchronized levels.
- Bus conditions:
  - START = sda_fall while synchronized SCL = 1.
  - STOP = sda_rise while synchronized SCL = 1.
  - START/STOP take priority over bit processing in the same cycle.
- Sampling and driving:
  - Data bits are sampled on scl_rise, MSB first, into the shift register.
  - i2c_sda_oe changes only on scl_fall, START or STOP.
- States: IDLE, ADDRESS, ADDR_ACK, REGISTER, REG_ACK, DATA, DATA_ACK, IGNORE.
- IDLE:
  - START -> ADDRESS, bit counter 0.
  - All bus edges other than START are ignored.
- ADDRESS / REGISTER / DATA:
  - Each scl_rise shifts in one bit and increments the counter.
  - On the 8th bit the byte is complete: counter returns to 0 and the byte is latched.
- Byte-complete actions:
  - ADDRESS, byte[7:1]==own_address and byte[0]==0: on the next scl_fall set i2c_sda_oe=1, busy=1 -> ADDR_ACK.
  - ADDRESS, address mismatch or byte[0]==1: i2c_sda_oe stays 0 -> IGNORE.
  - REGISTER: latch byte into the internal address pointer; on the next scl_fall set i2c_sda_oe=1 -> REG_ACK.
  - DATA: in the cycle after the scl_rise of bit 0:
    - data=byte, register_address=pointer, data_valid=1 for exactly one cycle.
    - On the next scl_fall set i2c_sda_oe=1 -> DATA_ACK.
    - Pointer increments by 1 (8-bit wrap, 0xFF->0x00) after the strobe when AUTO_INCREMENT=1.
- Leaving ACK states: the scl_fall ending the 9th clock clears i2c_sda_oe.
  - ADDR_ACK -> REGISTER.
  - REG_ACK -> DATA.
  - DATA_ACK -> DATA.
- IGNORE: waits for STOP or START; i2c_sda_oe=0 throughout.
- Repeated START in any state:
  - i2c_sda_oe=0, counter 0 -> ADDRESS.
  - busy holds its value until the next address decision.
  - Pointer is retained.
- STOP in any state: i2c_sda_oe=0, busy=0, counter 0 -> IDLE.
- START or STOP with counter in 1..7: bus_error strobes one cycle; the partial byte is discarded and produces no data_valid.
- register_address and data hold their last values between strobes.
- Reset asserted mid-transaction: SDA released the same cycle the reset is registered; no data_valid is issued for the partial byte.
- Timing requirement: the SCL low phase must last ≥ SYNC_STAGES+3 system clocks so ACK is driven before the next rise.
- Latency: pin edge to internal strobe = SYNC_STAGES+1 clocks.

Test Plan:
- own_address=0x50. START, 0xA0, 0x12, 0x34, STOP -> ACK on all three 9th clocks; one data_valid with register_address=0x12, data=0x34; busy high START..STOP.
- Same header, data bytes 0x01,0x02,0x03, register 0xFE, AUTO_INCREMENT=1 -> three strobes at addresses 0xFE, 0xFF, 0x00 (wrap); data 0x01, 0x02, 0x03.
- Address byte 0xA2 (mismatch), then 0x10, 0x20 -> i2c_sda_oe never asserts; no data_valid; busy stays 0.
- Address byte 0xA1 (read to own address) -> NACK (i2c_sda_oe=0 at 9th clock), IGNORE until STOP.
- START, 0xA0, 4 bits of 0x12, STOP -> bus_error one cycle; no data_valid; FSM IDLE; i2c_sda_oe=0.
- reset=1 while i2c_sda_oe=1 during ADDR_ACK -> i2c_sda_oe=0 next cycle; all outputs 0; a new START/0xA0 transfer then ACKs normally.
